// File: rtl/ram_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_streamer
// Brief    : Streams a base/length window from a 1-cycle-latency RAM read port
//            as a valid/ready stream with last marking. Optional stall counter
//            enabled by defining RD_STREAM_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rd_streamer #(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 256,
    localparam int ADDR_WIDTH = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1,
    localparam int LEN_WIDTH  = $clog2(WORD_COUNT + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [WORD_WIDTH-1:0] ram_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WORD_WIDTH-1:0] m_data_o,
    output logic                  m_last_o
`ifdef RD_STREAM_STATS_EN
    ,
    output logic [15:0]           stall_cnt_o
`endif
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_addr_max = ADDR_WIDTH'(WORD_COUNT - 1);
    localparam logic [LEN_WIDTH-1:0]  c_len_one  = LEN_WIDTH'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_issue_left;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_in_flight;
    logic                  r_flight_last;

    logic [WORD_WIDTH-1:0] r_fifo_d0;
    logic [WORD_WIDTH-1:0] r_fifo_d1;
    logic                  r_fifo_l0;
    logic                  r_fifo_l1;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic [1:0]            w_cnt_after_pop;
    logic [2:0]            w_credit;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_last_hs;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;

    assign m_valid_o  = (r_count != 2'd0);
    assign m_data_o   = r_fifo_d0;
    assign m_last_o   = r_fifo_l0;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign ram_addr_o = r_addr;

    assign w_pop           = m_valid_o && m_ready_i;
    assign w_push          = r_in_flight;
    assign w_cnt_after_pop = r_count - {1'b0, w_pop};
    // Words already buffered plus the one still inside the RAM must leave room.
    assign w_credit   = {1'b0, r_count} + {2'b00, r_in_flight} - {2'b00, w_pop};
    assign w_issue    = (r_state == c_st_run) && (w_credit < 3'd2);
    assign w_accept   = (r_state == c_st_idle) && start_i;
    assign w_last_hs  = w_pop && r_fifo_l0;
    assign w_addr_nxt = (r_addr == c_addr_max) ? '0 : r_addr + ADDR_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (start_i && (len_i != '0)) w_state_nxt = c_st_run;
            c_st_run:   if (w_issue && (r_issue_left == c_len_one)) w_state_nxt = c_st_drain;
            c_st_drain: if (w_last_hs) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr        <= '0;
            r_issue_left  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_in_flight   <= 1'b0;
            r_flight_last <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_in_flight   <= w_issue;
            r_flight_last <= w_issue && (r_issue_left == c_len_one);
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_issue_left <= len_i;
                            r_addr       <= base_addr_i;
                            r_busy       <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_st_run: begin
                    if (w_issue) begin
                        r_issue_left <= r_issue_left - c_len_one;
                        r_addr       <= w_addr_nxt;
                    end
                end
                c_st_drain: begin
                    if (w_last_hs) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shift-register FIFO: entry 0 is always the head driving the stream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fifo_d0 <= '0;
            r_fifo_d1 <= '0;
            r_fifo_l0 <= 1'b0;
            r_fifo_l1 <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_pop) begin
                r_fifo_d0 <= r_fifo_d1;
                r_fifo_l0 <= r_fifo_l1;
                r_fifo_l1 <= 1'b0;
            end
            if (w_push) begin
                if (w_cnt_after_pop == 2'd0) begin
                    r_fifo_d0 <= ram_data_i;
                    r_fifo_l0 <= r_flight_last;
                end else begin
                    r_fifo_d1 <= ram_data_i;
                    r_fifo_l1 <= r_flight_last;
                end
            end
            r_count <= w_cnt_after_pop + {1'b0, w_push};
        end
    end

`ifdef RD_STREAM_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_accept) begin
            r_stall_cnt <= '0;
        end else if (r_busy && m_valid_o && !m_ready_i && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
